// File: rtl/memo_trans_pkg.sv
// Shared definitions for the memory-transfer engine: FSM state encodings and a
// clog2 helper used to size the counters and address ports.
package memo_trans_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RD0  = 3'd2;
  localparam logic [2:0] ST_RD1  = 3'd3;
  localparam logic [2:0] ST_WR   = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    RD0  = ST_RD0,
    RD1  = ST_RD1,
    WR   = ST_WR
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pair_alu.sv
// Combinational pair reducer: a0 > a1 gives a0 - a1, otherwise a0 + a1.
// Build option MEMO_TRANS_SAT_ADD_EN saturates the add path instead of wrapping.
module pair_alu #(
  parameter int W = 8
) (
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  output logic [W-1:0] res
);

`ifdef MEMO_TRANS_SAT_ADD_EN
  logic [W:0] sum;
  assign sum = {1'b0, a0} + {1'b0, a1};
`endif

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    res = a0 - a1;
    if (a0 <= a1) begin
`ifdef MEMO_TRANS_SAT_ADD_EN
      res = sum[W] ? '1 : sum[W-1:0];
`else
      res = a0 + a1;
`endif
    end
  end

endmodule

// File: rtl/memo_trans_engine.sv
// Memory-transfer engine: streams DEPTH_A words into A, reduces them pairwise into B,
// and serves registered reads of B while idle. Optional macro: MEMO_TRANS_SAT_ADD_EN.
module memo_trans_engine
  import memo_trans_pkg::*;
#(
  parameter int W       = 8,
  parameter int DEPTH_A = 8,
  localparam int AW     = clog2(DEPTH_A),
  localparam int BW     = (AW > 1) ? AW - 1 : 1
) (
  input  logic          clock,
  input  logic          Reset_n,
  input  logic          load_valid,
  input  logic [W-1:0]  load_data,
  output logic          load_ready,
  output logic          busy,
  output logic          done,
  input  logic          rd_en,
  input  logic [BW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid
);

  localparam int NB = DEPTH_A / 2;

  state_t        state, state_nxt;
  logic [AW-1:0] lcnt;
  logic [BW-1:0] pcnt;
  logic [AW-1:0] a_idx;
  logic [W-1:0]  hold, hold2, alu_res;
  logic          load_fire, lcnt_last, pcnt_last, rd_fire;

  logic [W-1:0]  mem_a [DEPTH_A];
  logic [W-1:0]  mem_b [NB];

  assign load_ready = (state == IDLE) || (state == LOAD);
  assign busy       = (state == RD0) || (state == RD1) || (state == WR);
  assign load_fire  = load_ready && load_valid;
  assign lcnt_last  = (lcnt == AW'(DEPTH_A - 1));
  assign pcnt_last  = (pcnt == BW'(NB - 1));
  assign rd_fire    = rd_en && !busy;
  // Even word in RD0, odd word in RD1 of the current pair.
  assign a_idx      = AW'({pcnt, (state == RD1)});

  pair_alu #(.W(W)) u_alu (
    .a0  (hold),
    .a1  (hold2),
    .res (alu_res)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load_valid) state_nxt = LOAD;
      LOAD: if (load_valid && lcnt_last) state_nxt = RD0;
      RD0:  state_nxt = RD1;
      RD1:  state_nxt = WR;
      WR:   state_nxt = pcnt_last ? IDLE : RD0;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      lcnt     <= '0;
      pcnt     <= '0;
      hold     <= '0;
      hold2    <= '0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= state_nxt;
      done     <= (state == WR) && pcnt_last;
      rd_valid <= rd_fire;
      if (load_fire) lcnt <= lcnt_last ? '0 : lcnt + 1'b1;
      if (state == RD0) hold  <= mem_a[a_idx];
      if (state == RD1) hold2 <= mem_a[a_idx];
      if (state == WR)  pcnt  <= pcnt_last ? '0 : pcnt + 1'b1;
      if (rd_fire) rd_data <= mem_b[rd_addr];
    end
  end

  // NOTE: the arrays sit outside the reset branch; their contents survive reset and map to plain RAM.
  always_ff @(posedge clock) begin
    if (load_fire)    mem_a[lcnt] <= load_data;
    if (state == WR)  mem_b[pcnt] <= alu_res;
  end

endmodule
